ilm_iter_mult: RTL and testbench

Sequential, parametrised iterative logarithmic multiplier (ILM). Successor to the single-shot combinational ILM. It adds configurable operand width, a run-time number of error-correction iterations, run-time signed or unsigned mode, and valid/ready handshakes on both sides. It sits in the approximate-arithmetic datapath where accuracy is traded against latency per operation.

---
 rtl/ilm_iter_mult_pkg.sv | 16 +
 rtl/ilm_iter_mult_if.sv | 30 +++
 rtl/ilm_lod.sv | 20 ++
 rtl/ilm_iter_mult.sv | 117 +++++++++++
 tb/tb_ilm_iter_mult.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ilm_iter_mult_pkg.sv
// Shared types and helpers for the iterative logarithmic multiplier.
package ilm_pkg;

    localparam int ILM_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ilm_state_t;

    function automatic int unsigned clamp_iters(input int unsigned it, input int unsigned max_iter);
        return (it > max_iter) ? max_iter : it;
    endfunction

endpackage

// File: rtl/ilm_iter_mult_if.sv
// Request/response handshake bundle for ilm_iter_mult.
interface ilm_iter_mult_if
    import ilm_pkg::*;
#(
    parameter int WIDTH    = ILM_DEFAULT_WIDTH,
    parameter int MAX_ITER = 3,
    parameter int ITW      = $clog2(MAX_ITER + 1)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               signed_en;
    logic [ITW-1:0]     iters;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               exact;
    logic               busy;

    modport master (
        output in_valid, in1, in2, signed_en, iters, out_ready,
        input  in_ready, out_valid, product, exact, busy
    );

    modport slave (
        input  in_valid, in1, in2, signed_en, iters, out_ready,
        output in_ready, out_valid, product, exact, busy
    );
endinterface

// File: rtl/ilm_lod.sv
// Combinational leading-one detector: position of the top set bit and the
// value with that bit cleared.
module ilm_lod #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] v,
    output logic [KW-1:0]    k,
    output logic [WIDTH-1:0] x,
    output logic             zero
);
    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) k = KW'(i);
        end
        x    = v & ~(WIDTH'(1) << k);
        zero = (v == '0);
    end
endmodule

// File: rtl/ilm_iter_mult.sv
// Sequential iterative logarithmic multiplier: one ILM correction term per
// cycle on the residues, stopping early once either residue reaches zero.
module ilm_iter_mult
    import ilm_pkg::*;
#(
    parameter  int WIDTH    = ILM_DEFAULT_WIDTH,
    parameter  int MAX_ITER = 3,
    localparam int ITW      = $clog2(MAX_ITER + 1),
    localparam int KW       = $clog2(WIDTH),
    localparam int PW       = 2 * WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    ilm_iter_mult_if.slave  bus
);
    ilm_state_t     state_reg;
    logic [WIDTH-1:0] res_reg [2];
    logic [PW-1:0]  acc_reg;
    logic [PW-1:0]  product_reg;
    logic [ITW-1:0] j_reg;
    logic [ITW-1:0] iters_reg;
    logic           sign_reg;
    logic           exact_reg;

    logic [WIDTH-1:0] opnd  [2];
    logic [WIDTH-1:0] mag   [2];
    logic [KW-1:0]    lod_k [2];
    logic [WIDTH-1:0] lod_x [2];
    logic             lod_zero [2];

    assign opnd[0] = bus.in1;
    assign opnd[1] = bus.in2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_op
            // -2^(WIDTH-1) negates onto itself, which reads correctly as unsigned.
            assign mag[gi] = (bus.signed_en && opnd[gi][WIDTH-1]) ? ('0 - opnd[gi]) : opnd[gi];

            ilm_lod #(.WIDTH(WIDTH)) u_lod (
                .v    (res_reg[gi]),
                .k    (lod_k[gi]),
                .x    (lod_x[gi]),
                .zero (lod_zero[gi])
            );
        end
    endgenerate

    logic [PW-1:0] term;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] product_next;
    logic          res_zero_next;
    logic          last_iter;

    always_comb begin
        term = '0;
        if (!(lod_zero[0] || lod_zero[1])) begin
            term = (PW'(1) << ((KW+1)'(lod_k[0]) + (KW+1)'(lod_k[1])))
                 + (PW'(lod_x[0]) << lod_k[1])
                 + (PW'(lod_x[1]) << lod_k[0]);
        end
        acc_next      = acc_reg + term;
        product_next  = sign_reg ? ('0 - acc_next) : acc_next;
        res_zero_next = (lod_x[0] == '0) || (lod_x[1] == '0);
        last_iter     = (j_reg == iters_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            res_reg[0]  <= '0;
            res_reg[1]  <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            j_reg       <= '0;
            iters_reg   <= '0;
            sign_reg    <= 1'b0;
            exact_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        res_reg[0]  <= mag[0];
                        res_reg[1]  <= mag[1];
                        sign_reg    <= bus.signed_en & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                        iters_reg   <= ITW'(clamp_iters(32'(bus.iters), MAX_ITER));
                        acc_reg     <= '0;
                        product_reg <= '0;
                        j_reg       <= '0;
                        exact_reg   <= 1'b0;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    acc_reg    <= acc_next;
                    res_reg[0] <= lod_x[0];
                    res_reg[1] <= lod_x[1];
                    j_reg      <= j_reg + ITW'(1);
                    if (res_zero_next || last_iter) begin
                        exact_reg   <= res_zero_next;
                        product_reg <= product_next;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.product   = product_reg;
    assign bus.exact     = exact_reg;
endmodule

// File: tb/tb_ilm_iter_mult.sv
// Directed and randomized bench for ilm_iter_mult against an arithmetic ILM model.
module tb_ilm_iter_mult;
    localparam int W   = 8;
    localparam int MI  = 3;
    localparam int ITW = $clog2(MI + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ilm_iter_mult_if #(.WIDTH(W), .MAX_ITER(MI)) bus ();

    ilm_iter_mult #(.WIDTH(W), .MAX_ITER(MI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] obs_p;
    logic           obs_e;
    int             obs_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned top_pow(input int unsigned v);
        int unsigned p = 1;
        while (p * 2 <= v) p = p * 2;
        return p;
    endfunction

    // After n terms the accumulated sum equals A*B minus the product of the residues.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg, input int it,
                         output logic [2*W-1:0] p, output logic ex, output int m);
        int unsigned a_full, b_full, a, b, lim;
        longint acc;
        logic s;
        a_full = (sg && x[W-1]) ? (int'(1 << W) - int'(x)) : int'(x);
        b_full = (sg && y[W-1]) ? (int'(1 << W) - int'(y)) : int'(y);
        s   = sg & (x[W-1] ^ y[W-1]);
        lim = (it > MI) ? MI : it;
        a = a_full; b = b_full; m = 0; ex = 1'b0;
        for (int n = 0; n <= int'(lim); n++) begin
            m = n + 1;
            if (a == 0 || b == 0) begin ex = 1'b1; break; end
            a = a - top_pow(a);
            b = b - top_pow(b);
            if (a == 0 || b == 0) begin ex = 1'b1; break; end
        end
        acc = longint'(a_full) * longint'(b_full) - longint'(a) * longint'(b);
        p   = s ? (2*W)'(-acc) : (2*W)'(acc);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                         input int it, input int stall);
        logic [2*W-1:0] ep;
        logic           ee;
        int             em;
        model(x, y, sg, it, ep, ee, em);
        bus.in1 = x; bus.in2 = y; bus.signed_en = sg; bus.iters = ITW'(it);
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        #1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        // Post-accept input changes must not affect the operation.
        bus.in_valid = 1'b0; bus.signed_en = ~sg; bus.iters = '0; bus.in1 = ~x;
        obs_m = 0;
        do begin
            @(posedge clk); #1;
            obs_m++;
        end while (!bus.out_valid && obs_m < 40);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        obs_p = bus.product;
        obs_e = bus.exact;
        check("product", 32'(obs_p), 32'(ep));
        check("exact", 32'(obs_e), 32'(ee));
        check("latency", obs_m, em);
        $display("op %02h x %02h signed=%0d iters=%0d stall=%0d -> product=%04h exact=%0d m=%0d (model %04h %0d %0d)",
                 x, y, sg, it, stall, obs_p, obs_e, obs_m, ep, ee, em);
        if (stall > 0) begin
            bus.in_valid = 1'b1; bus.in1 = ~x;
            for (int c = 0; c < stall; c++) begin
                @(posedge clk); #1;
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_product", 32'(bus.product), 32'(ep));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_busy", 32'(bus.busy), 32'd1);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("drop_valid", 32'(bus.out_valid), 32'd0);
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        if (stall > 0) begin
            @(posedge clk); #1;
            check("stay_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.signed_en = 1'b0;
        bus.iters = '0; bus.out_ready = 1'b1;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_exact", 32'(bus.exact), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'd5, 8'd3, 1'b0, 1, 0);
        check("5x3_i1_p", 32'(obs_p), 32'd15); check("5x3_i1_e", 32'(obs_e), 32'd1); check("5x3_i1_m", obs_m, 2);
        do_op(8'd5, 8'd3, 1'b0, 0, 0);
        check("5x3_i0_p", 32'(obs_p), 32'd14); check("5x3_i0_e", 32'(obs_e), 32'd0); check("5x3_i0_m", obs_m, 1);
        do_op(8'd255, 8'd255, 1'b0, 0, 0);
        check("255sq_i0_p", 32'(obs_p), 32'd48896); check("255sq_i0_e", 32'(obs_e), 32'd0);
        do_op(8'd255, 8'd255, 1'b0, 1, 0);
        check("255sq_i1_p", 32'(obs_p), 32'd61056); check("255sq_i1_e", 32'(obs_e), 32'd0); check("255sq_i1_m", obs_m, 2);
        do_op(8'd255, 8'd255, 1'b0, 7, 0);
        check("255sq_imax_m", obs_m, 4);
        do_op(8'd129, 8'd65, 1'b0, 0, 0);
        check("129x65_i0_p", 32'(obs_p), 32'd8384); check("129x65_i0_e", 32'(obs_e), 32'd0);
        do_op(8'd129, 8'd65, 1'b0, 3, 0);
        check("129x65_i3_p", 32'(obs_p), 32'd8385); check("129x65_i3_e", 32'(obs_e), 32'd1); check("129x65_i3_m", obs_m, 2);
        do_op(8'hFB, 8'd3, 1'b1, 1, 0);
        check("m5x3_p", 32'(obs_p), 32'hFFF1); check("m5x3_e", 32'(obs_e), 32'd1);
        do_op(8'h80, 8'h80, 1'b1, 2, 0);
        check("m128sq_p", 32'(obs_p), 32'd16384); check("m128sq_e", 32'(obs_e), 32'd1); check("m128sq_m", obs_m, 1);
        do_op(8'd0, 8'd18, 1'b1, 3, 0);
        check("0x18_p", 32'(obs_p), 32'd0); check("0x18_e", 32'(obs_e), 32'd1); check("0x18_m", obs_m, 1);
        do_op(8'd255, 8'd255, 1'b0, 2, 5);

        // Abort mid-CALC with an asynchronous reset.
        bus.in1 = 8'd255; bus.in2 = 8'd255; bus.signed_en = 1'b0; bus.iters = ITW'(3);
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        $display("reset abort mid-CALC: out_valid=%0d product=%04h", bus.out_valid, bus.product);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'd1, 8'd1, 1'b0, 0, 0);
        check("1x1_p", 32'(obs_p), 32'd1); check("1x1_e", 32'(obs_e), 32'd1); check("1x1_m", obs_m, 1);

        for (int r = 0; r < 40; r++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
